dac7611_rx: RTL

Serial-input receiver for the DAC7611 three-wire interface (DAC_CLK, CS, SDI) plus its LD and CLR control lines. Runs inside the FPGA on the system clock and oversamples the DAC7611 driver's outputs. Reconstructs the 12-bit input register and DAC register exactly as the converter would, and flags malformed frames. Used for loopback self-test and for on-board monitoring of what the DAC was actually sent.

---
 rtl/dac7611_rx_if.sv | 31 +++
 rtl/dac7611_rx.sv | 137 +++++++++++++
 2 files changed

// File: rtl/dac7611_rx_if.sv
// Pin and result bundle for the DAC7611 serial receiver.
// master drives the DAC7611 pins, slave is the receiver.
interface dac7611_rx_if #(
    parameter int WIDTH = 12
);
    logic             DAC_CLK;
    logic             CS;
    logic             SDI;
    logic             LD;
    logic             CLR;
    logic [WIDTH-1:0] rx_word;
    logic             rx_valid;
    logic [WIDTH-1:0] dac_value;
    logic             load_pulse;
    logic             clr_pulse;
    logic             err_short;
    logic             err_long;
    logic             busy;

    modport master (
        output DAC_CLK, CS, SDI, LD, CLR,
        input  rx_word, rx_valid, dac_value, load_pulse, clr_pulse,
               err_short, err_long, busy
    );

    modport slave (
        input  DAC_CLK, CS, SDI, LD, CLR,
        output rx_word, rx_valid, dac_value, load_pulse, clr_pulse,
               err_short, err_long, busy
    );
endinterface

// File: rtl/dac7611_rx.sv
// Oversampling receiver that rebuilds the DAC7611 input and DAC registers.
// Define DAC7611_RX_SYNC_EN for a 2-stage pin synchronizer (default 1 stage).
//
// state | meaning
// IDLE  | CS high, waiting for a frame to start
// SHIFT | CS low, shifting SDI on each DAC_CLK rising edge
module dac7611_rx #(
    parameter int WIDTH = 12
) (
    input  logic         clk,
    input  logic         reset,
    dac7611_rx_if.slave  bus
);
`ifdef DAC7611_RX_SYNC_EN
    localparam int N = 2;
`else
    localparam int N = 1;
`endif
    // pin vector order {DAC_CLK, CS, SDI, LD, CLR}; idle levels avoid edges out of reset
    localparam logic [4:0] PIN_IDLE = 5'b01011;
    localparam logic [4:0] CNT_W    = 5'(WIDTH);
    localparam logic [4:0] CNT_MAX  = 5'd31;

    typedef enum logic {IDLE, SHIFT} state_t;

    logic [4:0]       sync_q [N];
    logic [4:0]       prev_q;
    logic [4:0]       pins;
    logic [4:0]       s;
    logic             s_dac_clk, s_cs, s_sdi, s_ld, s_clr;
    logic             dclk_rise, cs_fall, cs_rise, ld_fall, clr_fall;

    state_t           state;
    logic [WIDTH-1:0] sr;
    logic [4:0]       cnt;
    logic [WIDTH-1:0] rx_word_q;
    logic [WIDTH-1:0] dac_value_q;
    logic             rx_valid_q, load_pulse_q, clr_pulse_q;
    logic             err_short_q, err_long_q, busy_q;

    assign pins = {bus.DAC_CLK, bus.CS, bus.SDI, bus.LD, bus.CLR};
    assign s    = sync_q[N-1];

    assign s_dac_clk = s[4];
    assign s_cs      = s[3];
    assign s_sdi     = s[2];
    assign s_ld      = s[1];
    assign s_clr     = s[0];

    assign dclk_rise = s_dac_clk & ~prev_q[4];
    assign cs_fall   = ~s_cs & prev_q[3];
    assign cs_rise   = s_cs & ~prev_q[3];
    assign ld_fall   = ~s_ld & prev_q[1];
    assign clr_fall  = ~s_clr & prev_q[0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N; i++) sync_q[i] <= PIN_IDLE;
            prev_q <= PIN_IDLE;
        end else begin
            sync_q[0] <= pins;
            for (int i = 1; i < N; i++) sync_q[i] <= sync_q[i-1];
            prev_q <= s;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            sr           <= '0;
            cnt          <= '0;
            rx_word_q    <= '0;
            dac_value_q  <= '0;
            rx_valid_q   <= 1'b0;
            load_pulse_q <= 1'b0;
            clr_pulse_q  <= 1'b0;
            err_short_q  <= 1'b0;
            err_long_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            rx_valid_q   <= 1'b0;
            err_short_q  <= 1'b0;
            err_long_q   <= 1'b0;
            load_pulse_q <= ld_fall;
            clr_pulse_q  <= clr_fall;

            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        cnt    <= '0;
                        sr     <= '0;
                        state  <= SHIFT;
                        busy_q <= 1'b1;
                    end
                end
                SHIFT: begin
                    // a clock edge seen together with CS rising is dropped
                    if (cs_rise) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                        if (cnt >= CNT_W) begin
                            rx_word_q  <= sr;
                            rx_valid_q <= 1'b1;
                            err_long_q <= (cnt != CNT_W);
                        end else begin
                            err_short_q <= 1'b1;
                        end
                    end else if (dclk_rise && !s_cs) begin
                        sr <= {sr[WIDTH-2:0], s_sdi};
                        if (cnt != CNT_MAX) cnt <= cnt + 5'd1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase

            // CLR wins over LD and over a completing frame
            if (!s_clr) begin
                rx_word_q   <= '0;
                dac_value_q <= '0;
            end else if (!s_ld) begin
                dac_value_q <= rx_word_q;
            end
        end
    end

    assign bus.rx_word    = rx_word_q;
    assign bus.rx_valid   = rx_valid_q;
    assign bus.dac_value  = dac_value_q;
    assign bus.load_pulse = load_pulse_q;
    assign bus.clr_pulse  = clr_pulse_q;
    assign bus.err_short  = err_short_q;
    assign bus.err_long   = err_long_q;
    assign bus.busy       = busy_q;
endmodule
